// File: rtl/geogenius_pkg.sv
// Shared definitions for the answer-playback block: state codes,
// debug code for invalid states, default timing and timer width.
package geogenius_pkg;

    typedef enum logic [3:0] {
        OCIOSO  = 4'd0,
        LE      = 4'd1,
        ACESO   = 4'd2,
        APAGADO = 4'd3,
        FIM     = 4'd4
    } estado_t;

    localparam logic [3:0] DB_INVALIDO = 4'hB;

    localparam int T_ON_PAD    = 1000;
    localparam int T_OFF_PAD   = 500;
    localparam int TIMER_W_PAD = 16;

endpackage

// File: rtl/sequenciador_exibicao_if.sv
// Control/memory bus between the game control unit, the answer memory
// and the playback sequencer. pausa only exists with PAUSA_EN defined.
// master: control side (drives start/abort/memory data)
// slave : sequencer side (drives address, LEDs and status)
interface sequenciador_exibicao_if #(
    parameter int ADDR_W = 4,
    parameter int DATA_W = 4
);
    logic              iniciar_exibicao;
    logic [ADDR_W-1:0] num_itens;
    logic              abortar;
    logic [DATA_W-1:0] mem_dado;
`ifdef PAUSA_EN
    logic              pausa;
`endif
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] leds;
    logic              ocupado;
    logic              fim_exibicao;
    logic [3:0]        db_estado;

    modport master (
`ifdef PAUSA_EN
        output pausa,
`endif
        output iniciar_exibicao,
        output num_itens,
        output abortar,
        output mem_dado,
        input  mem_addr,
        input  leds,
        input  ocupado,
        input  fim_exibicao,
        input  db_estado
    );

    modport slave (
`ifdef PAUSA_EN
        input  pausa,
`endif
        input  iniciar_exibicao,
        input  num_itens,
        input  abortar,
        input  mem_dado,
        output mem_addr,
        output leds,
        output ocupado,
        output fim_exibicao,
        output db_estado
    );

endinterface

// File: rtl/timer_exibicao.sv
// Phase timer for LED playback: clears on zera, advances on conta,
// fim is high while the count equals the programmed limite.
// Ports: clock, reset (async high), zera, conta, limite, fim.
module timer_exibicao #(
    parameter int TIMER_W = 16
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               zera,
    input  logic               conta,
    input  logic [TIMER_W-1:0] limite,
    output logic               fim
);

    logic [TIMER_W-1:0] valor;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            valor <= '0;
        end else if (zera) begin
            valor <= '0;
        end else if (conta) begin
            valor <= valor + TIMER_W'(1);
        end
    end

    assign fim = (valor == limite);

endmodule

// File: rtl/sequenciador_exibicao.sv
// Plays back answer memory items 0..num_itens on the LEDs, each lit for
// T_ON cycles then blanked T_OFF cycles; start/done handshake with control.
// Ports: clock, reset (async high), bus (slave modport: iniciar_exibicao,
//   num_itens, abortar, mem_dado, [pausa], mem_addr, leds, ocupado,
//   fim_exibicao, db_estado). Optional macro PAUSA_EN adds timer freeze.
module sequenciador_exibicao
    import geogenius_pkg::*;
#(
    parameter int ADDR_W  = 4,
    parameter int DATA_W  = 4,
    parameter int T_ON    = T_ON_PAD,
    parameter int T_OFF   = T_OFF_PAD,
    parameter int TIMER_W = TIMER_W_PAD
) (
    input  logic                  clock,
    input  logic                  reset,
    sequenciador_exibicao_if.slave bus
);

    estado_t            estado;
    logic [ADDR_W-1:0]  addr_q;
    logic [ADDR_W-1:0]  ultimo;
    logic [DATA_W-1:0]  leds_q;
    logic [TIMER_W-1:0] limite;
    logic               em_contagem;
    logic               pausado;
    logic               expirou;
    logic               avanca;
    logic               zera;
    logic               conta;

    assign em_contagem = (estado == ACESO) || (estado == APAGADO);

`ifdef PAUSA_EN
    assign pausado = bus.pausa & em_contagem;
`else
    assign pausado = 1'b0;
`endif

    // A phase ends only on an unpaused expiry; the timer is held at zero
    // outside the timed states so every phase starts from a clean count.
    assign avanca = expirou & ~pausado;
    assign zera   = ~em_contagem | avanca;
    assign conta  = ~pausado;
    assign limite = (estado == ACESO) ? TIMER_W'(T_ON - 1)
                                      : TIMER_W'(T_OFF - 1);

    timer_exibicao #(
        .TIMER_W (TIMER_W)
    ) u_timer (
        .clock  (clock),
        .reset  (reset),
        .zera   (zera),
        .conta  (conta),
        .limite (limite),
        .fim    (expirou)
    );

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            estado <= OCIOSO;
            addr_q <= '0;
            leds_q <= '0;
            ultimo <= '0;
        end else begin
            unique case (estado)
                OCIOSO: begin
                    if (bus.iniciar_exibicao) begin
                        addr_q <= '0;
                        ultimo <= bus.num_itens;
                        estado <= LE;
                    end
                end
                LE: begin
                    if (bus.abortar) begin
                        leds_q <= '0;
                        addr_q <= '0;
                        estado <= OCIOSO;
                    end else begin
                        leds_q <= bus.mem_dado;
                        estado <= ACESO;
                    end
                end
                ACESO: begin
                    if (bus.abortar) begin
                        leds_q <= '0;
                        addr_q <= '0;
                        estado <= OCIOSO;
                    end else if (avanca) begin
                        leds_q <= '0;
                        estado <= APAGADO;
                    end
                end
                APAGADO: begin
                    if (bus.abortar) begin
                        leds_q <= '0;
                        addr_q <= '0;
                        estado <= OCIOSO;
                    end else if (avanca) begin
                        if (addr_q == ultimo) begin
                            estado <= FIM;
                        end else begin
                            addr_q <= addr_q + ADDR_W'(1);
                            estado <= LE;
                        end
                    end
                end
                FIM: begin
                    estado <= OCIOSO;
                end
                default: begin
                    leds_q <= '0;
                    addr_q <= '0;
                    estado <= OCIOSO;
                end
            endcase
        end
    end

    always_comb begin
        bus.db_estado = DB_INVALIDO;
        case (estado)
            OCIOSO, LE, ACESO, APAGADO, FIM: bus.db_estado = estado;
            default:                         bus.db_estado = DB_INVALIDO;
        endcase
    end

    assign bus.ocupado      = em_contagem || (estado == LE);
    assign bus.fim_exibicao = (estado == FIM);
    assign bus.mem_addr     = addr_q;
    assign bus.leds         = leds_q;

endmodule

// File: tb/tb_sequenciador_exibicao.sv
// Self-checking bench for sequenciador_exibicao with T_ON=4, T_OFF=2.
// Expected per-cycle outputs are queued at start and popped each cycle.
module tb_sequenciador_exibicao;
    import geogenius_pkg::*;

    localparam int TON  = 4;
    localparam int TOFF = 2;

    typedef struct {
        logic [3:0] leds;
        logic [3:0] addr;
        logic [3:0] db;
        logic       ocup;
        logic       fim;
    } exp_t;

    logic clock;
    logic reset;
    logic [3:0] mem [16];
    exp_t q[$];
    int checks;
    int errors;

    sequenciador_exibicao_if #(.ADDR_W(4), .DATA_W(4)) bus ();

    sequenciador_exibicao #(
        .ADDR_W  (4),
        .DATA_W  (4),
        .T_ON    (TON),
        .T_OFF   (TOFF),
        .TIMER_W (16)
    ) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    assign bus.mem_dado = mem[bus.mem_addr];

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic push_e(input logic [3:0] l, input logic [3:0] a,
                          input logic [3:0] d, input logic o,
                          input logic f);
        exp_t e;
        e.leds = l; e.addr = a; e.db = d; e.ocup = o; e.fim = f;
        q.push_back(e);
    endtask

    // Independent trace model: LE, T_ON lit (plus extra on item 0),
    // T_OFF blank per item, then FIM and idle. Abort truncates.
    task automatic build(input int last, input int abort_k,
                         input int extra0);
        for (int i = 0; i <= last; i++) begin
            push_e(4'd0, 4'(i), 4'd1, 1'b1, 1'b0);
            for (int c = 0; c < TON + ((i == 0) ? extra0 : 0); c++)
                push_e(mem[i], 4'(i), 4'd2, 1'b1, 1'b0);
            for (int c = 0; c < TOFF; c++)
                push_e(4'd0, 4'(i), 4'd3, 1'b1, 1'b0);
        end
        push_e(4'd0, 4'(last), 4'd4, 1'b0, 1'b1);
        push_e(4'd0, 4'(last), 4'd0, 1'b0, 1'b0);
        push_e(4'd0, 4'(last), 4'd0, 1'b0, 1'b0);
        if (abort_k >= 0) begin
            while (q.size() > abort_k + 1) void'(q.pop_back());
            for (int c = 0; c < 4; c++)
                push_e(4'd0, 4'd0, 4'd0, 1'b0, 1'b0);
        end
    endtask

    task automatic tick();
        exp_t e;
        @(posedge clock);
        #1;
        if (q.size() > 0) begin
            e = q.pop_front();
            chk("leds", 32'(bus.leds), 32'(e.leds));
            chk("mem_addr", 32'(bus.mem_addr), 32'(e.addr));
            chk("db_estado", 32'(bus.db_estado), 32'(e.db));
            chk("ocupado", 32'(bus.ocupado), 32'(e.ocup));
            chk("fim", 32'(bus.fim_exibicao), 32'(e.fim));
        end
    endtask

    task automatic clear_in();
        bus.iniciar_exibicao = 1'b0;
        bus.abortar = 1'b0;
`ifdef PAUSA_EN
        bus.pausa = 1'b0;
`endif
    endtask

    task automatic run(input int last, input int abort_k,
                       input int extra0, input int restart_k,
                       input int pause_k);
        int j;
        build(last, abort_k, extra0);
        bus.num_itens = 4'(last);
        bus.iniciar_exibicao = 1'b1;
        tick();
        j = 0;
        while (q.size() > 0 && j < 400) begin
            bus.abortar = (j == abort_k);
            bus.iniciar_exibicao = (restart_k >= 0) && (j >= restart_k)
                                   && (j < restart_k + 2);
            if (restart_k >= 0 && j >= restart_k) bus.num_itens = 4'd5;
`ifdef PAUSA_EN
            bus.pausa = (pause_k >= 0) && (j >= pause_k)
                        && (j < pause_k + 3);
`endif
            tick();
            j++;
        end
        clear_in();
        chk("drain", 32'(q.size()), 32'd0);
    endtask

    initial begin
        checks = 0;
        errors = 0;
        for (int i = 0; i < 16; i++) mem[i] = 4'(15 - i);
        bus.num_itens = 4'd0;
        clear_in();
        reset = 1'b1;
        #12;
        chk("rst_leds", 32'(bus.leds), 32'd0);
        chk("rst_addr", 32'(bus.mem_addr), 32'd0);
        chk("rst_db", 32'(bus.db_estado), 32'd0);
        chk("rst_ocup", 32'(bus.ocupado), 32'd0);
        chk("rst_fim", 32'(bus.fim_exibicao), 32'd0);
        @(negedge clock);
        reset = 1'b0;

        mem[0] = 4'd3; mem[1] = 4'd5; mem[2] = 4'd9;
        run(2, -1, 0, -1, -1);

        mem[0] = 4'hA;
        run(0, -1, 0, -1, -1);

        mem[0] = 4'd3;
        run(2, 9, 0, -1, -1);
        run(2, 4, 0, -1, -1);
        run(2, -1, 0, 5, -1);

`ifdef PAUSA_EN
        run(2, -1, 3, -1, 1);
`endif

        for (int i = 0; i < 16; i++) mem[i] = 4'(15 - i);
        run(15, -1, 0, -1, -1);

        build(2, -1, 0);
        bus.num_itens = 4'd2;
        bus.iniciar_exibicao = 1'b1;
        tick();
        bus.iniciar_exibicao = 1'b0;
        for (int k = 0; k < 5; k++) tick();
        #2 reset = 1'b1;
        #1;
        chk("arst_db", 32'(bus.db_estado), 32'd0);
        chk("arst_leds", 32'(bus.leds), 32'd0);
        chk("arst_ocup", 32'(bus.ocupado), 32'd0);
        chk("arst_addr", 32'(bus.mem_addr), 32'd0);
        q.delete();
        @(negedge clock);
        reset = 1'b0;
        push_e(4'd0, 4'd0, 4'd0, 1'b0, 1'b0);
        tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
